// File: rtl/input_debounce.sv
// Two-flop synchronizer plus counting FSM that debounces a bouncy switch input.
// Optional debounced edge pulses x_rise/x_fall with INPUT_DEBOUNCE_EDGE_EN.
module input_debounce #(
  parameter int DB_CYCLES = 8,
  parameter int CNT_W     = 4
) (
  input  logic       Clk,
  input  logic       rst,
  input  logic       x_raw,
  output logic       x,
  output logic       stable,
  output logic [7:0] glitch_cnt
`ifdef INPUT_DEBOUNCE_EDGE_EN
  ,
  output logic       x_rise,
  output logic       x_fall
`endif
);

  typedef enum logic [1:0] {
    LO,
    WAIT_HI,
    HI,
    WAIT_LO
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             s1;
  logic             s2;
  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             x_n;
  logic             glitch_hit;

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= x_raw;
      s2 <= s1;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    x_n        = x;
    glitch_hit = 1'b0;
    unique case (state)
      LO: begin
        x_n = 1'b0;
        if (s2) begin
          state_n = WAIT_HI;
          cnt_n   = '0;
        end
      end
      WAIT_HI: begin
        if (!s2) begin
          state_n    = LO;
          cnt_n      = '0;
          glitch_hit = 1'b1;
        end else if (cnt == CNT_MAX) begin
          state_n = HI;
          cnt_n   = '0;
          x_n     = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HI: begin
        x_n = 1'b1;
        if (!s2) begin
          state_n = WAIT_LO;
          cnt_n   = '0;
        end
      end
      WAIT_LO: begin
        if (s2) begin
          state_n    = HI;
          cnt_n      = '0;
          glitch_hit = 1'b1;
        end else if (cnt == CNT_MAX) begin
          state_n = LO;
          cnt_n   = '0;
          x_n     = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = LO;
        cnt_n   = '0;
        x_n     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state <= LO;
      cnt   <= '0;
      x     <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      x     <= x_n;
    end
  end

  // Saturates so a chattering contact cannot wrap the count back to zero
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      glitch_cnt <= 8'd0;
    end else if (glitch_hit && glitch_cnt != 8'hFF) begin
      glitch_cnt <= glitch_cnt + 8'd1;
    end
  end

  assign stable = (state == LO) || (state == HI);

`ifdef INPUT_DEBOUNCE_EDGE_EN
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      x_rise <= 1'b0;
      x_fall <= 1'b0;
    end else begin
      x_rise <= x_n & ~x;
      x_fall <= ~x_n & x;
    end
  end
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Bench for input_debounce: directed table, reset/latency sequences and
// random runs checked against a run-length reference model.
module tb_input_debounce;

  localparam int DB = 8;

  logic       Clk;
  logic       rst;
  logic       x_raw;
  logic       x;
  logic       stable;
  logic [7:0] glitch_cnt;
`ifdef INPUT_DEBOUNCE_EDGE_EN
  logic       x_rise;
  logic       x_fall;
`endif

  int checks = 0;
  int errors = 0;

  input_debounce #(.DB_CYCLES(DB), .CNT_W(4)) dut (
    .Clk        (Clk),
    .rst        (rst),
    .x_raw      (x_raw),
    .x          (x),
    .stable     (stable),
    .glitch_cnt (glitch_cnt)
`ifdef INPUT_DEBOUNCE_EDGE_EN
    ,
    .x_rise     (x_rise),
    .x_fall     (x_fall)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Model: two-sample delay line, then count consecutive samples that
  // disagree with the output; DB+1 of them flip it, a shorter run is a glitch.
  bit m1, m2, mx, mrise, mfall;
  int run;
  int mg;

  function automatic void model_reset();
    m1 = 0; m2 = 0; mx = 0; run = 0; mg = 0;
    mrise = 0; mfall = 0;
  endfunction

  function automatic void model_step(input bit v);
    mrise = 0;
    mfall = 0;
    if (m2 != mx) begin
      run++;
      if (run == DB + 1) begin
        mrise = m2;
        mfall = !m2;
        mx    = m2;
        run   = 0;
      end
    end else begin
      if (run > 0 && mg < 255) mg++;
      run = 0;
    end
    m2 = m1;
    m1 = v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    check("x", x, mx);
    check("stable", stable, run == 0);
    check("glitch_cnt", glitch_cnt, mg);
`ifdef INPUT_DEBOUNCE_EDGE_EN
    check("x_rise", x_rise, mrise);
    check("x_fall", x_fall, mfall);
    check("rise_fall_excl", x_rise & x_fall, 0);
`endif
  endtask

  task automatic tick(input bit v);
    x_raw = v;
    @(posedge Clk);
    model_step(v);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("rst_x", x, 0);
    check("rst_stable", stable, 1);
    check("rst_glitch", glitch_cnt, 0);
    @(negedge Clk);
    rst = 1'b1;
  endtask

  typedef struct {
    bit raw;
    int cycles;
    bit exp_x;
    bit exp_stable;
    int exp_glitch;
  } vec_t;

  vec_t tbl[$];
  int   lat;
  bit   done;
  bit   cur;

  initial begin
    rst   = 1'b1;
    x_raw = 1'b0;
    model_reset();
    @(negedge Clk);
    do_reset();

    // Directed segments with hand-derived end states
    tbl.push_back('{0, 20, 0, 1, 0});
    tbl.push_back('{1, 2, 0, 1, 0});
    tbl.push_back('{1, 1, 0, 0, 0});
    tbl.push_back('{1, 7, 0, 0, 0});
    tbl.push_back('{1, 1, 1, 1, 0});
    tbl.push_back('{1, 5, 1, 1, 0});
    tbl.push_back('{0, 10, 1, 0, 0});
    tbl.push_back('{0, 1, 0, 1, 0});
    tbl.push_back('{0, 5, 0, 1, 0});
    for (int p = 0; p < 3; p++) begin
      tbl.push_back('{1, 3, 0, 0, p});
      tbl.push_back('{0, 4, 0, 1, p + 1});
    end
    tbl.push_back('{0, 6, 0, 1, 3});

    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].cycles; c++) tick(tbl[i].raw);
      check($sformatf("tbl%0d_x", i), x, tbl[i].exp_x);
      check($sformatf("tbl%0d_stable", i), stable, tbl[i].exp_stable);
      check($sformatf("tbl%0d_glitch", i), glitch_cnt, tbl[i].exp_glitch);
    end

    // Reset in WAIT_HI with cnt at 5 (edge 8 of a held high)
    @(negedge Clk);
    do_reset();
    for (int c = 0; c < 8; c++) tick(1'b1);
    check("pre_rst_stable", stable, 0);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("midwait_x", x, 0);
    check("midwait_stable", stable, 1);
    check("midwait_glitch", glitch_cnt, 0);
    @(negedge Clk);
    rst = 1'b1;
    lat  = 0;
    done = 0;
    for (int c = 1; c <= 30 && !done; c++) begin
      tick(1'b1);
      if (x) begin
        lat  = c;
        done = 1;
      end
    end
    check("fresh_latency", lat, DB + 3);

    // Saturation after 260 aborted pulses
    for (int c = 0; c < 4; c++) tick(1'b1);
    for (int c = 0; c < 12; c++) tick(1'b0);
    @(negedge Clk);
    do_reset();
    for (int p = 0; p < 260; p++) begin
      tick(1'b1);
      for (int c = 0; c < 3; c++) tick(1'b0);
    end
    check("sat_255", glitch_cnt, 255);
    for (int p = 0; p < 3; p++) begin
      tick(1'b1);
      for (int c = 0; c < 3; c++) tick(1'b0);
    end
    check("sat_hold", glitch_cnt, 255);

    // Random runs of mixed length around the debounce threshold
    @(negedge Clk);
    do_reset();
    cur = 0;
    for (int r = 0; r < 250; r++) begin
      int len;
      cur = ~cur;
      len = $urandom_range(1, 14);
      for (int c = 0; c < len; c++) tick(cur);
    end
    for (int c = 0; c < 15; c++) tick(cur);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_debounce.md
INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 The module SHALL have parameter DB_CYCLES, default 8, meaning the number of consecutive stable synchronized samples required before the output changes (legal range 1..2^CNT_W-1).
REQ-002 The module SHALL have parameter CNT_W, default 4, meaning the width of the debounce counter.
REQ-003 The module SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port x_raw, input, 1 bit: the asynchronous, bouncy control input from a switch or pin.
REQ-006 The module SHALL have port x, output, 1 bit: the debounced, registered level that drives the x input of the downstream state machine.
REQ-007 The module SHALL have port stable, output, 1 bit: high while no candidate change is pending.
REQ-008 The module SHALL have port glitch_cnt, output, 8 bits: the saturating count of rejected pulses.
REQ-009 The module SHALL have port x_rise, output, 1 bit, present only with INPUT_DEBOUNCE_EDGE_EN: a one-cycle pulse on each debounced rising transition.
REQ-010 The module SHALL have port x_fall, output, 1 bit, present only with INPUT_DEBOUNCE_EDGE_EN: a one-cycle pulse on each debounced falling transition.

Function
REQ-011 Synchronizer: x_raw SHALL pass through two flops (s1, then s2); only s2 feeds the FSM.
REQ-012 The FSM SHALL have four states: LO, WAIT_HI, HI and WAIT_LO.
REQ-013 In LO: x=0 and stable=1; when s2=1, the FSM SHALL go to WAIT_HI with cnt=0.
REQ-014 In WAIT_HI with s2=0: the FSM SHALL return to LO, clear cnt, increment glitch_cnt, and keep x=0.
REQ-015 In WAIT_HI with s2=1 and cnt=DB_CYCLES-1: the FSM SHALL go to HI and set x=1; with s2=1 and any other cnt value, it SHALL increment cnt.
REQ-016 HI, WAIT_LO: the behaviour SHALL mirror REQ-013 to REQ-015 with polarities inverted (x=1 in HI; x=0 on entry to LO from WAIT_LO).
REQ-017 stable SHALL be 0 in WAIT_HI and WAIT_LO, and 1 in LO and HI.
REQ-018 Latency: counting the first rising edge that samples x_raw=1 as edge 1, x SHALL go high at edge DB_CYCLES+3 (edge 11 at default), provided x_raw stays 1 throughout; falling-edge latency SHALL be identical.
REQ-019 Any x_raw pulse that yields fewer than DB_CYCLES+1 consecutive s2 samples at the new level SHALL NOT change x.
REQ-020 glitch_cnt SHALL increment by exactly 1 per aborted WAIT state and saturate at 255 with no wrap.
REQ-021 x SHALL be a flop output, never combinational from x_raw.
REQ-022 cnt SHALL never exceed DB_CYCLES-1.

Reset
REQ-023 While rst=0, the block SHALL asynchronously force s1=0, s2=0, state=LO, cnt=0, x=0, stable=1, glitch_cnt=0, x_rise=0 and x_fall=0.
REQ-024 Reset asserted mid-WAIT SHALL abandon the pending change without incrementing glitch_cnt.
REQ-025 After rst deasserts, operation SHALL resume on the first rising Clk edge.

Configuration
REQ-026 With macro INPUT_DEBOUNCE_EDGE_EN defined, x_rise SHALL be 1 for exactly the cycle in which x first reads 1 after being 0 (likewise x_fall for 1->0), with both registered and never high simultaneously.
REQ-027 Without INPUT_DEBOUNCE_EDGE_EN, the ports x_rise and x_fall and their logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-028 Reset pulse, then x_raw held 0 for 20 cycles -> x=0, stable=1, glitch_cnt=0 throughout.
REQ-029 x_raw 0->1 held (DB_CYCLES=8) -> stable=0 from edge 3; x=1 at edge 11; with EDGE_EN, x_rise=1 for exactly that one cycle.
REQ-030 Three x_raw high pulses of 3 cycles each, separated by 4 low cycles -> x stays 0, glitch_cnt=3.
REQ-031 From x=1, x_raw 1->0 held -> x=0 at edge 11 after the first 0 sample; with EDGE_EN, a single x_fall pulse.
REQ-032 rst driven low during WAIT_HI at cnt=5 -> immediate x=0, state LO, glitch_cnt unchanged at 0; after release, a fresh 11-edge latency applies.
REQ-033 Force 260 aborted glitches -> glitch_cnt reads 255 and holds.
